// File: rtl/alu_sequencer.sv
// Command/result sequencer around an external combinational ALU.
// It registers the operands, captures and corrects the result, and tracks sticky flags and a result count.
module alu_sequencer #(
  parameter logic [7:0] DIV0_VAL = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [3:0] cmd_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flag,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [3:0] res_flag,
  output logic       res_err,
  input  logic       clr_sticky,
  output logic [3:0] sticky_flag,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  localparam logic [3:0] OpDiv     = 4'h3;
  localparam logic [3:0] OpLastLegal = 4'hB;

  state_e state;

  logic       accept;
  logic       capture;
  logic       illegal_op;
  logic       div_zero;
  logic [7:0] res_data_new;
  logic [3:0] res_flag_new;
  logic       res_err_new;
  logic [3:0] sticky_next;

  // A consumed result frees the slot in the same cycle, so DONE can accept directly.
  assign cmd_ready = (state == StIdle) || ((state == StDone) && res_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign capture   = (state == StExec);

  assign illegal_op = (alu_sel > OpLastLegal);
  assign div_zero   = (alu_sel == OpDiv) && (alu_b == 8'h00);

  always_comb begin
    res_data_new = alu_out;
    res_flag_new = {alu_flag[3:1], (alu_out == 8'h00)};
    res_err_new  = 1'b0;
    if (illegal_op) begin
      res_data_new = 8'h00;
      res_flag_new = 4'b0000;
      res_err_new  = 1'b1;
    end else if (div_zero) begin
      // alu_out may be X here; never let it reach the result.
      res_data_new = DIV0_VAL;
      res_flag_new = 4'b0100;
      res_err_new  = 1'b1;
    end
  end

  always_comb begin
    sticky_next = sticky_flag;
    if (clr_sticky) begin
      sticky_next = capture ? res_flag_new : 4'b0000;
    end else if (capture) begin
      sticky_next = sticky_flag | res_flag_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      alu_sel     <= 4'h0;
      res_valid   <= 1'b0;
      res_data    <= 8'h00;
      res_flag    <= 4'b0000;
      res_err     <= 1'b0;
      sticky_flag <= 4'b0000;
      op_count    <= 8'h00;
    end else begin
      sticky_flag <= sticky_next;
      if (accept) begin
        alu_a   <= cmd_a;
        alu_b   <= cmd_b;
        alu_sel <= cmd_sel;
      end
      case (state)
        StIdle: begin
          if (accept) state <= StExec;
        end
        StExec: begin
          res_data  <= res_data_new;
          res_flag  <= res_flag_new;
          res_err   <= res_err_new;
          res_valid <= 1'b1;
          op_count  <= op_count + 8'd1;
          state     <= StDone;
        end
        StDone: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= cmd_valid ? StExec : StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a small behavioural ALU attached.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] cmd_sel;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic [3:0] alu_flag;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [3:0] res_flag;
  logic       res_err;
  logic       clr_sticky;
  logic [3:0] sticky_flag;
  logic [7:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_cnt;
  logic [3:0] exp_sticky;
  logic [7:0] start_cnt;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_sel     (cmd_sel),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_flag    (alu_flag),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_flag    (res_flag),
    .res_err     (res_err),
    .clr_sticky  (clr_sticky),
    .sticky_flag (sticky_flag),
    .op_count    (op_count)
  );

  // Reference ALU: flags {under, over, carry, zero}; zero flag deliberately inverted.
  logic [8:0]  sum9;
  logic [15:0] prod;
  always_comb begin
    sum9     = {1'b0, alu_a} + {1'b0, alu_b};
    prod     = alu_a * alu_b;
    alu_out  = alu_a;
    alu_flag = 4'b0000;
    case (alu_sel)
      4'h0: begin alu_out = sum9[7:0]; alu_flag[1] = sum9[8]; end
      4'h1: begin alu_out = alu_a - alu_b; alu_flag[3] = (alu_a < alu_b); end
      4'h2: alu_out = alu_a & alu_b;
      4'h3: begin
        if (alu_b != 8'h00) alu_out = alu_a / alu_b;
        else begin alu_out = 8'hxx; alu_flag = 4'bxxxx; end
      end
      4'h4: alu_out = alu_a | alu_b;
      4'h5: alu_out = alu_a ^ alu_b;
      4'h6: begin alu_out = prod[7:0]; alu_flag[2] = (prod[15:8] != 8'h00); end
      default: alu_out = alu_a;
    endcase
    if (alu_sel != 4'h3 || alu_b != 8'h00) alu_flag[0] = (alu_out != 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_sel"}, alu_sel, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_flag"}, res_flag, 0);
    chk({tag, "_res_err"}, res_err, 0);
    chk({tag, "_sticky"}, sticky_flag, 0);
    chk({tag, "_op_count"}, op_count, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  // One full command/result transaction starting from IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                        input logic [7:0] ed, input logic [3:0] ef, input logic ee);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel; res_ready = 1'b0;
    chk("idle_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = 8'h5A; cmd_b = 8'hA5; cmd_sel = 4'hF;
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_alu_sel", alu_sel, sel);
    chk("exec_cmd_ready", cmd_ready, 0);
    chk("exec_res_valid", res_valid, 0);
    @(posedge clk); #1;
    exp_cnt    = exp_cnt + 8'd1;
    exp_sticky = exp_sticky | ef;
    chk("done_res_valid", res_valid, 1);
    chk("done_res_data", res_data, ed);
    chk("done_res_flag", res_flag, ef);
    chk("done_res_err", res_err, ee);
    chk("done_op_count", op_count, exp_cnt);
    chk("done_sticky", sticky_flag, exp_sticky);
    chk("done_alu_sel_held", alu_sel, sel);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("consumed_res_valid", res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_sel = 4'h0;
    res_ready = 1'b0; clr_sticky = 1'b0;
    exp_cnt = 8'h00; exp_sticky = 4'b0000;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 4'h0, 8'h08, 4'b0000, 1'b0);
    run_op(8'h80, 8'h80, 4'h0, 8'h00, 4'b0011, 1'b0);
    run_op(8'h01, 8'h02, 4'h1, 8'hFF, 4'b1000, 1'b0);
    chk("sticky_1011", sticky_flag, 4'b1011);
    run_op(8'h10, 8'h00, 4'h3, 8'hFF, 4'b0100, 1'b1);
    run_op(8'h10, 8'h03, 4'h3, 8'h05, 4'b0000, 1'b0);
    run_op(8'h10, 8'h20, 4'h6, 8'h00, 4'b0101, 1'b0);
    run_op(8'h00, 8'h33, 4'hB, 8'h00, 4'b0001, 1'b0);
    run_op(8'h77, 8'h33, 4'hC, 8'h00, 4'b0000, 1'b1);
    run_op(8'h12, 8'h34, 4'hD, 8'h00, 4'b0000, 1'b1);

    // Backpressure in DONE with a command waiting.
    cmd_valid = 1'b1; cmd_a = 8'h21; cmd_b = 8'h12; cmd_sel = 4'h0; res_ready = 1'b0;
    @(posedge clk); #1;
    cmd_a = 8'h40; cmd_b = 8'h02; cmd_sel = 4'h1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, 8'h33);
      chk("bp_res_flag", res_flag, 4'b0000);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_alu_a_held", alu_a, 8'h21);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    #1 chk("bp_cmd_ready_comb", cmd_ready, 1);
    @(posedge clk); #1;
    res_ready = 1'b0; cmd_valid = 1'b0;
    chk("bp_accept_res_valid", res_valid, 0);
    chk("bp_accept_alu_a", alu_a, 8'h40);
    chk("bp_accept_alu_sel", alu_sel, 4'h1);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    chk("bp_next_res_valid", res_valid, 1);
    chk("bp_next_res_data", res_data, 8'h3E);
    chk("bp_next_op_count", op_count, exp_cnt);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Clear coincident with a capture of flag 0010.
    cmd_valid = 1'b1; cmd_a = 8'hFF; cmd_b = 8'h02; cmd_sel = 4'h0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("clr_cap_res_data", res_data, 8'h01);
    chk("clr_cap_res_flag", res_flag, 4'b0010);
    chk("clr_cap_sticky", sticky_flag, 4'b0010);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    chk("clr_idle_sticky", sticky_flag, 4'b0000);

    // 256 back-to-back results wrap op_count to its starting value.
    start_cnt = exp_cnt;
    cmd_valid = 1'b1; cmd_a = 8'h00; cmd_b = 8'hFF; cmd_sel = 4'h2; res_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      repeat (2) @(posedge clk);
      #1;
      exp_cnt = exp_cnt + 8'd1;
      chk("b2b_res_valid", res_valid, 1);
      chk("b2b_op_count", op_count, exp_cnt);
    end
    chk("b2b_wrap", op_count, start_cnt);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("b2b_sticky", sticky_flag, 4'b0001);
    chk("b2b_idle_ready", cmd_ready, 1);

    // Reset in the middle of EXEC.
    cmd_valid = 1'b1; cmd_a = 8'h05; cmd_b = 8'h06; cmd_sel = 4'h0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("mid_exec_cmd_ready", cmd_ready, 0);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 8'h00; exp_sticky = 4'b0000;
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_rst_res_valid", res_valid, 0);
      chk("post_rst_cmd_ready", cmd_ready, 1);
    end
    run_op(8'h03, 8'h04, 4'h0, 8'h07, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
